// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core: fetch into ir, then step
// DECODE/EXEC/MEM/WB, gating write strobes once per instruction, with memory timeouts and traps.
module cpu_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instr_in,
  output logic [31:0]      ir,
  input  logic             dec_we_regfile,
  input  logic             dec_we_datamem,
  input  logic             dec_re_datamem,
  input  logic             dec_we_pc,
  input  logic             dec_j_pc,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             regfile_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       ir_q;
  logic [CNT_W-1:0]  retired_q;
  logic              legal_op;

  always_comb begin
    legal_op = 1'b0;
    case (ir_q[6:0])
      7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  // Timeout fires in the MEM_TIMEOUT-th request cycle when ready is still low.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q >= WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC:   state_d = (dec_we_datamem | dec_re_datamem) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (wait_q >= WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= '0;
      wait_q    <= '0;
      ir_q      <= NOP;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_FETCH && imem_ready) begin
        ir_q <= instr_in;
      end
      if (state_q == S_WB) begin
        retired_q <= retired_q + 1'b1;
      end
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if ((state_q == S_FETCH || state_q == S_MEM) && wait_q != '1) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regfile_we = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    halted     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_we_datamem;
        end
        S_WB: begin
          regfile_we = dec_we_regfile;
          pc_we      = 1'b1;
          if (dec_j_pc) begin
            pc_src = 2'b10;
          end else if (dec_we_pc && branch_taken) begin
            pc_src = 2'b01;
          end
        end
        S_TRAP:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir         = ir_q;
  assign retired    = retired_q;
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: builds a per-cycle expectation schedule from instruction-level
// rules (fetch wait, decode, exec, optional memory wait, writeback) and checks the DUT each cycle.
module tb_cpu_seq_ctrl;
  localparam int unsigned T = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] instr_in, ir, retired;
  logic        dec_we_regfile, dec_we_datamem, dec_re_datamem, dec_we_pc, dec_j_pc, branch_taken;
  logic        regfile_we, pc_we, halted;
  logic [1:0]  pc_src, trap_cause;
  logic [2:0]  state;

  cpu_seq_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready), .instr_in(instr_in),
    .ir(ir), .dec_we_regfile(dec_we_regfile), .dec_we_datamem(dec_we_datamem),
    .dec_re_datamem(dec_re_datamem), .dec_we_pc(dec_we_pc), .dec_j_pc(dec_j_pc),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .regfile_we(regfile_we), .pc_we(pc_we), .pc_src(pc_src), .halted(halted),
    .trap_cause(trap_cause), .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dec bits: [0] we_regfile, [1] we_datamem, [2] re_datamem, [3] we_pc, [4] j_pc
  typedef struct {
    logic        rst, imem_ready, dmem_ready, bt, chk_full;
    logic [31:0] instr;
    logic [4:0]  dec;
    logic [2:0]  st;
    logic        imem_req, dmem_req, dmem_we, regfile_we, pc_we, halted;
    logic [1:0]  pc_src, cause;
    logic [31:0] ir, retired;
  } cyc_t;

  cyc_t        sched[$];
  logic [31:0] m_ir = NOP;
  logic [31:0] m_ret = '0;
  bit          m_trapped = 0;
  int          total = 0, bad = 0;
  int          pc_we_seen = 0, rf_we_seen = 0, dreq_seen = 0;

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    for (int i = 0; i < 9; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 1'b0; c.imem_ready = 1'($urandom); c.dmem_ready = 1'($urandom);
    c.bt = 1'($urandom); c.instr = $urandom; c.dec = 5'($urandom); c.chk_full = 1'b1;
    c.st = 3'd0; c.imem_req = 0; c.dmem_req = 0; c.dmem_we = 0; c.regfile_we = 0;
    c.pc_we = 0; c.halted = 0; c.pc_src = 2'b00; c.cause = 2'b00;
    c.ir = m_ir; c.retired = m_ret;
    return c;
  endfunction

  task automatic push_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(); c.rst = 1'b1; c.chk_full = 1'b0;
      sched.push_back(c);
    end
    m_ir = NOP; m_ret = '0; m_trapped = 0;
  endtask

  task automatic push_trap(input logic [1:0] cause, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(); c.st = 3'd5; c.halted = 1'b1; c.cause = cause;
      sched.push_back(c);
    end
    m_trapped = 1;
  endtask

  // wi/wd: wait cycles before ready (>= T means never ready); abort_mem: MEM cycle at which rst hits
  task automatic add_instr(input logic [31:0] instr, input logic [4:0] dec, input logic bt,
                           input int wi, input int wd, input int abort_mem);
    cyc_t c;
    for (int k = 0; k < int'(T); k++) begin
      c = blank(); c.imem_req = 1'b1; c.imem_ready = (k == wi);
      if (k == wi) c.instr = instr;
      sched.push_back(c);
      if (k == wi) break;
    end
    if (wi >= int'(T)) begin push_trap(2'b10, 6); return; end
    m_ir = instr;
    c = blank(); c.st = 3'd1; c.dec = dec; sched.push_back(c);
    if (!is_legal(instr[6:0])) begin push_trap(2'b01, 20); return; end
    c = blank(); c.st = 3'd2; c.dec = dec; sched.push_back(c);
    if (dec[1] | dec[2]) begin
      for (int k = 0; k < int'(T); k++) begin
        if (k == abort_mem) begin push_reset(2); return; end
        c = blank(); c.st = 3'd3; c.dec = dec; c.dmem_req = 1'b1; c.dmem_we = dec[1];
        c.dmem_ready = (k == wd);
        sched.push_back(c);
        if (k == wd) break;
      end
      if (wd >= int'(T)) begin push_trap(2'b11, 6); return; end
    end
    c = blank(); c.st = 3'd4; c.dec = dec; c.bt = bt;
    c.regfile_we = dec[0]; c.pc_we = 1'b1;
    c.pc_src = dec[4] ? 2'b10 : ((dec[3] && bt) ? 2'b01 : 2'b00);
    sched.push_back(c);
    m_ret = m_ret + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run();
    cyc_t c;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      @(negedge clk);
      rst = c.rst; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready; instr_in = c.instr;
      {dec_j_pc, dec_we_pc, dec_re_datamem, dec_we_datamem, dec_we_regfile} = c.dec;
      branch_taken = c.bt;
      #1;
      chk("imem_req", 32'(imem_req), 32'(c.imem_req));
      chk("dmem_req", 32'(dmem_req), 32'(c.dmem_req));
      chk("dmem_we", 32'(dmem_we), 32'(c.dmem_we));
      chk("regfile_we", 32'(regfile_we), 32'(c.regfile_we));
      chk("pc_we", 32'(pc_we), 32'(c.pc_we));
      chk("halted", 32'(halted), 32'(c.halted));
      if (c.chk_full) begin
        chk("state", 32'(state), 32'(c.st));
        chk("pc_src", 32'(pc_src), 32'(c.pc_src));
        chk("trap_cause", 32'(trap_cause), 32'(c.cause));
        chk("ir", ir, c.ir);
        chk("retired", retired, c.retired);
      end
      if (pc_we === 1'b1) pc_we_seen++;
      if (regfile_we === 1'b1) rf_we_seen++;
      if (dmem_req === 1'b1) dreq_seen++;
    end
  endtask

  task automatic clr_seen();
    pc_we_seen = 0; rf_we_seen = 0; dreq_seen = 0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; imem_ready = 0; dmem_ready = 0; instr_in = '0; branch_taken = 0;
    {dec_j_pc, dec_we_pc, dec_re_datamem, dec_we_datamem, dec_we_regfile} = '0;

    // ADD with immediate ready
    push_reset(2);
    n0 = sched.size();
    add_instr(32'h00B50533, 5'b00001, 1'b0, 0, 0, -1);
    chk("add_cycles", 32'(sched.size() - n0), 32'd4);
    run();
    chk("add_pc_we_pulses", 32'(pc_we_seen), 32'd1);
    chk("add_rf_we_pulses", 32'(rf_we_seen), 32'd1);

    // LW with 3 waits (ready in the T-th cycle), SW, BEQ taken, JAL, ADDI with slow fetch
    clr_seen();
    n0 = sched.size();
    add_instr(32'h00052503, 5'b00101, 1'b0, 0, 3, -1);
    chk("lw_cycles", 32'(sched.size() - n0), 32'd8);
    add_instr(32'h00B52023, 5'b00010, 1'b0, 0, 0, -1);
    add_instr(32'h00B50463, 5'b01000, 1'b1, 0, 0, -1);
    add_instr(32'h0100006F, 5'b11001, 1'b0, 0, 0, -1);
    n0 = sched.size();
    add_instr(32'h00100093, 5'b00001, 1'b0, 3, 0, -1);
    chk("slow_fetch_cycles", 32'(sched.size() - n0), 32'd7);
    run();
    chk("mem_req_cycles", 32'(dreq_seen), 32'd5);
    chk("seq_rf_we_pulses", 32'(rf_we_seen), 32'd3);
    chk("seq_pc_we_pulses", 32'(pc_we_seen), 32'd5);
    chk("seq_retired_model", m_ret, 32'd6);

    // illegal opcode
    add_instr(32'h0000007F, 5'b00000, 1'b0, 0, 0, -1);
    run();
    chk("illegal_halted", 32'(halted), 32'd1);
    chk("illegal_cause", 32'(trap_cause), 32'd1);

    // dmem timeout
    push_reset(2);
    clr_seen();
    add_instr(32'h00052503, 5'b00101, 1'b0, 0, T, -1);
    run();
    chk("dmem_to_req_cycles", 32'(dreq_seen), 32'd4);
    chk("dmem_to_cause", 32'(trap_cause), 32'd3);

    // imem timeout
    push_reset(2);
    add_instr(32'h00B50533, 5'b00001, 1'b0, T, 0, -1);
    run();
    chk("imem_to_cause", 32'(trap_cause), 32'd2);

    // reset during MEM of a load, then an ADD
    push_reset(2);
    clr_seen();
    add_instr(32'h00052503, 5'b00101, 1'b0, 0, 3, 2);
    run();
    chk("abort_ir", ir, NOP);
    chk("abort_pc_we_pulses", 32'(pc_we_seen), 32'd0);
    add_instr(32'h00B50533, 5'b00001, 1'b0, 0, 0, -1);
    run();
    chk("after_abort_pc_we", 32'(pc_we_seen), 32'd1);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [6:0]  legal_ops [9];
      logic [31:0] ins;
      int wi, wd, ab;
      legal_ops = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      if (m_trapped) push_reset($urandom_range(1, 3));
      ins = $urandom;
      if ($urandom_range(0, 19) != 0) ins[6:0] = legal_ops[$urandom_range(0, 8)];
      wi = ($urandom_range(0, 24) == 0) ? int'(T) : $urandom_range(0, T - 1);
      wd = ($urandom_range(0, 24) == 0) ? int'(T) : $urandom_range(0, T - 1);
      ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, T - 1) : -1;
      add_instr(ins, 5'($urandom), 1'($urandom), wi, wd, ab);
      run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
